lc3_fetch_initiator: RTL and testbench
======================================

Name: lc3_fetch_initiator

Overview:
Instruction-fetch initiator for the LC3 core, acting as the master side of the inst_mem interface. It drives PC and instrmem_rd toward instruction memory and captures instr_dout when complete_instr is asserted. Fetched words go into a small prefetch queue, which feeds decode through a valid/ready handshake. The block also handles branch redirects: it flushes the queue and drains any in-flight fetch without corrupting the bus.

Parameters:
- PC_RESET, 16'h3000, fetch address after reset.
- PFQ_DEPTH, 2, prefetch queue entries (power of 2, at least 2).
- TIMEOUT_CYCLES, 64, watchdog limit; used only with the optional feature.

Ports:
- clock, input, 1, single clock; all logic on its rising edge.
- reset, input, 1, asynchronous active-low reset (0 = in reset).
- fetch_en, input, 1, allows issuing new fetches.
- PC, output, 16, fetch address on the inst_mem interface.
- instrmem_rd, output, 1, fetch request on the inst_mem interface.
- instr_dout, input, 16, fetched instruction; valid only while complete_instr=1.
- complete_instr, input, 1, responder completion strobe.
- instr_valid, output, 1, queue head is valid.
- instr, output, 16, queue head instruction.
- instr_pc, output, 16, address the head instruction was fetched from.
- instr_ready, input, 1, decode accepts the head.
- redirect, input, 1, branch/jump taken.
- redirect_pc, input, 16, new fetch address.
- fetch_err, output, 1, sticky fetch timeout flag.
- pfq_count, output, $clog2(PFQ_DEPTH)+1, current queue occupancy.

Behaviour:
- Reset asserted (asynchronous): PC=0, instrmem_rd=0, internal fetch_pc=PC_RESET, state=IDLE, queue empty, instr_valid=0, instr=0, instr_pc=0, fetch_err=0, watchdog=0.
- All outputs are registered. Only one fetch may be outstanding at a time.
- FSM states: IDLE, REQ, FLUSH.
- IDLE:
  - Condition: fetch_en=1, no redirect, and pfq_count<PFQ_DEPTH.
  - Action: next edge sets PC=fetch_pc, instrmem_rd=1, and moves to REQ.
- REQ:
  - Hold PC and instrmem_rd stable until complete_instr=1 is sampled.
  - On that edge: push {instr_dout, PC} into the queue, set fetch_pc=PC+1 (modulo 2^16, so FFFF wraps to 0000), drop instrmem_rd, and return to IDLE.
  - This guarantees at least one idle cycle between requests, which is what lets the responder retire complete_instr.
- complete_instr is ignored while instrmem_rd=0.
- Capacity: a fetch is issued only when there is a free slot (pfq_count<PFQ_DEPTH), so the queue never overflows. A pop in the issue cycle does not count toward freeing that slot.
- Queue output is show-ahead:
  - instr_valid=1 whenever the queue is non-empty; instr and instr_pc always reflect the head.
  - The head pops on instr_valid && instr_ready.
  - Simultaneous push and pop keeps the count unchanged.
- Redirect has the highest priority and takes effect on the edge it is sampled:
  - The queue is cleared; instr_valid=0 on the next cycle, even if a pop or push coincides.
  - fetch_pc is set to redirect_pc.
  - In REQ, the state moves to FLUSH.
- FLUSH:
  - Keep instrmem_rd and PC held, because the bus transaction cannot be aborted.
  - On complete_instr=1: discard the data, drop instrmem_rd, and go to IDLE.
  - Further redirects in FLUSH only update fetch_pc.
- fetch_en=0: no new fetch is issued; an outstanding REQ or FLUSH completes normally.
- Reset asserted mid-transaction: instrmem_rd falls immediately, and any in-flight data is lost.

Optional Feature:
- Macro: LC3_FETCH_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counts cycles while in REQ or FLUSH and clears on completion.
  - If it reaches TIMEOUT_CYCLES, fetch_err is set to 1 (sticky until reset), instrmem_rd drops, and the state returns to IDLE with no push.
  - fetch_pc is unchanged, so the fetch retries.
- Without the macro: fetch_err is tied to 0, no watchdog logic is present, and the block waits indefinitely.

Decomposition:
- Shared package lc3_fetch_pkg holds:
  - bit_16 typedef
  - fetch_state_t enum {IDLE, REQ, FLUSH}
  - pfq_entry_t struct {bit_16 instr; bit_16 pc}
  - LC3_PC_RESET constant (16'h3000)
- One sub-module, lc3_fetch_pfq:
  - Synchronous FIFO of pfq_entry_t, depth PFQ_DEPTH.
  - Async active-low reset, plus a synchronous flush input.
  - Show-ahead head output and a count output.

Test Plan:
1. Basic fetch: release reset with fetch_en=1; responder completes 2 cycles after instrmem_rd with 16'h1234 → PC=3000, instrmem_rd=1; then instr_valid=1 with instr=1234, instr_pc=3000; next request has PC=3001 after one idle cycle.
2. Backpressure: instr_ready=0, responder completes immediately → entries 3000 and 3001 queued, pfq_count=2, instrmem_rd stays 0. A single instr_ready pulse pops 3000, then a request for PC=3002 is issued.
3. Redirect while in REQ: redirect to 16'h4000 while fetching 3002 → queue empties next cycle; instrmem_rd held until complete; returned data discarded; next request has PC=4000.
4. PC wrap: redirect_pc=16'hFFFF, fetch completes with 16'h0ABC → instr_pc=FFFF, next request PC=0000.
5. Timeout (LC3_FETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=64): complete_instr never asserted → fetch_err=1 and instrmem_rd=0 exactly 64 cycles after instrmem_rd rose; retry issued with the same PC.
6. Reset mid-REQ: assert reset between clock edges → instrmem_rd=0 immediately and the queue is empty; after release, the first request has PC=3000.

Source files
------------

// File: rtl/lc3_fetch_pkg.sv
// Shared types and constants for the LC3 instruction-fetch initiator and its prefetch queue.
package lc3_fetch_pkg;

  typedef logic [15:0] bit_16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    bit_16 instr;
    bit_16 pc;
  } pfq_entry_t;

  localparam bit_16 LC3_PC_RESET = 16'h3000;

endpackage

// File: rtl/lc3_fetch_pfq.sv
// Show-ahead prefetch queue: a shift register whose slot 0 is always the head,
// so the head, valid flag and count are all plain registers.
module lc3_fetch_pfq
  import lc3_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  pfq_entry_t             push_data,
  input  logic                   pop,
  output logic                   head_valid,
  output pfq_entry_t             head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  pfq_entry_t       entries_reg  [DEPTH];
  pfq_entry_t       entries_next [DEPTH];
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] wr_idx;
  logic             valid_reg;
  logic             pop_ok;
  logic             push_ok;

  // A push lands just behind the last surviving entry after this cycle's pop.
  assign pop_ok     = pop && valid_reg;
  assign wr_idx     = count_reg - CNT_W'(pop_ok);
  assign push_ok    = push && (wr_idx < DEPTH_CNT);
  assign count_next = flush ? '0 : count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    pfq_entry_t shift_src;
    if (gi < DEPTH - 1) begin : g_mid
      assign shift_src = entries_reg[gi+1];
    end else begin : g_top
      assign shift_src = entries_reg[gi];
    end
    assign entries_next[gi] = flush                              ? entries_reg[gi] :
                              (push_ok && wr_idx == CNT_W'(gi)) ? push_data       :
                              pop_ok                             ? shift_src       :
                                                                   entries_reg[gi];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entries_reg <= '{default: '0};
      count_reg   <= '0;
      valid_reg   <= 1'b0;
    end else begin
      entries_reg <= entries_next;
      count_reg   <= count_next;
      valid_reg   <= (count_next != '0);
    end
  end

  assign head_valid = valid_reg;
  assign head       = entries_reg[0];
  assign count      = count_reg;

endmodule

// File: rtl/lc3_fetch_initiator.sv
// LC3 instruction-fetch master: one outstanding inst_mem read, prefetch queue, redirect/flush.
// Optional fetch watchdog enabled by defining LC3_FETCH_TIMEOUT_EN.
module lc3_fetch_initiator
  import lc3_fetch_pkg::*;
#(
  parameter bit_16 PC_RESET       = LC3_PC_RESET,
  parameter int    PFQ_DEPTH      = 2,
  parameter int    TIMEOUT_CYCLES = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       fetch_en,
  output logic [15:0]                PC,
  output logic                       instrmem_rd,
  input  logic [15:0]                instr_dout,
  input  logic                       complete_instr,
  output logic                       instr_valid,
  output logic [15:0]                instr,
  output logic [15:0]                instr_pc,
  input  logic                       instr_ready,
  input  logic                       redirect,
  input  logic [15:0]                redirect_pc,
  output logic                       fetch_err,
  output logic [$clog2(PFQ_DEPTH):0] pfq_count
);

  localparam int CNT_W = $clog2(PFQ_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(PFQ_DEPTH);

  fetch_state_t state_reg;
  bit_16        fetch_pc_reg;
  bit_16        pc_reg;
  logic         rd_reg;
  logic         timeout_hit;
  logic         push;
  pfq_entry_t   push_data;
  pfq_entry_t   head;

  assign push      = (state_reg == REQ) && complete_instr && !redirect;
  assign push_data = '{instr: instr_dout, pc: pc_reg};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= PC_RESET;
      pc_reg       <= '0;
      rd_reg       <= 1'b0;
    end else begin
      if (redirect) fetch_pc_reg <= redirect_pc;
      case (state_reg)
        IDLE: begin
          if (fetch_en && !redirect && pfq_count < DEPTH_CNT) begin
            pc_reg    <= fetch_pc_reg;
            rd_reg    <= 1'b1;
            state_reg <= REQ;
          end
        end
        REQ: begin
          if (complete_instr) begin
            rd_reg    <= 1'b0;
            state_reg <= IDLE;
            if (!redirect) fetch_pc_reg <= pc_reg + 16'd1;
          end else if (timeout_hit) begin
            rd_reg    <= 1'b0;
            state_reg <= IDLE;
          end else if (redirect) begin
            // The read cannot be aborted; wait for it and throw the data away.
            state_reg <= FLUSH;
          end
        end
        FLUSH: begin
          if (complete_instr || timeout_hit) begin
            rd_reg    <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          rd_reg    <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef LC3_FETCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_reg;
  logic            fetch_err_reg;

  // Fires on the edge that ends the TIMEOUT_CYCLES-th cycle of the request.
  assign timeout_hit = rd_reg && !complete_instr && (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_reg        <= '0;
      fetch_err_reg <= 1'b0;
    end else begin
      wd_reg        <= (rd_reg && !complete_instr && !timeout_hit) ? wd_reg + WD_W'(1) : '0;
      fetch_err_reg <= fetch_err_reg | timeout_hit;
    end
  end

  assign fetch_err = fetch_err_reg;
`else
  assign timeout_hit = 1'b0;
  // Without the watchdog the limit has no effect; this folds to a constant 0.
  assign fetch_err   = (TIMEOUT_CYCLES < 0);
`endif

  lc3_fetch_pfq #(
    .DEPTH(PFQ_DEPTH)
  ) u_pfq (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (instr_valid && instr_ready),
    .head_valid(instr_valid),
    .head      (head),
    .count     (pfq_count)
  );

  assign PC          = pc_reg;
  assign instrmem_rd = rd_reg;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_lc3_fetch_initiator.sv
// Self-checking bench for lc3_fetch_initiator: directed vector table, reset/timeout sequences,
// then randomized traffic against a queue-based reference model.
module tb_lc3_fetch_initiator;

  logic        clock;
  logic        reset;
  logic        fetch_en;
  logic [15:0] PC;
  logic        instrmem_rd;
  logic [15:0] instr_dout;
  logic        complete_instr;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        fetch_err;
  logic [1:0]  pfq_count;

  int n_checks = 0;
  int n_fail   = 0;

  lc3_fetch_initiator dut (
    .clock         (clock),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .PC            (PC),
    .instrmem_rd   (instrmem_rd),
    .instr_dout    (instr_dout),
    .complete_instr(complete_instr),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .fetch_err     (fetch_err),
    .pfq_count     (pfq_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        en, cpl;
    logic [15:0] dout;
    logic        rdy, redir;
    logic [15:0] rpc;
    logic        rd;
    logic [15:0] pc;
    logic        v;
    logic [15:0] ins, ipc;
    logic [1:0]  cnt;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic en, input logic cpl, input logic [15:0] dout,
                              input logic rdy, input logic redir, input logic [15:0] rpc,
                              input logic rd, input logic [15:0] pc, input logic v,
                              input logic [15:0] ins, input logic [15:0] ipc, input logic [1:0] cnt);
    vec_t r;
    r.en = en; r.cpl = cpl; r.dout = dout; r.rdy = rdy; r.redir = redir; r.rpc = rpc;
    r.rd = rd; r.pc = pc; r.v = v; r.ins = ins; r.ipc = ipc; r.cnt = cnt;
    return r;
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;

  localparam int DEPTH = 2;

  ent_t        m_q[$];
  bit          m_busy;
  bit          m_flush;
  logic [15:0] m_req_pc;
  logic [15:0] m_next_pc;

  task automatic model_reset();
    m_q.delete();
    m_busy    = 1'b0;
    m_flush   = 1'b0;
    m_req_pc  = 16'h0000;
    m_next_pc = 16'h3000;
  endtask

  // One clock edge of the fetch unit, expressed as transactions on a queue.
  task automatic model_step(input bit en, input bit cpl, input logic [15:0] dout,
                            input bit rdy, input bit redir, input logic [15:0] rpc);
    bit          was_busy = m_busy;
    int          pre_size = m_q.size();
    logic [15:0] pre_next = m_next_pc;
    bit          done     = was_busy && cpl;
    ent_t        e;
    if (done) m_busy = 1'b0;
    if (redir) begin
      m_q.delete();
      m_next_pc = rpc;
      if (done) m_flush = 1'b0;
      else if (was_busy) m_flush = 1'b1;
    end else begin
      if (pre_size > 0 && rdy) void'(m_q.pop_front());
      if (done) begin
        if (!m_flush) begin
          e.instr = dout;
          e.pc    = m_req_pc;
          m_q.push_back(e);
          m_next_pc = m_req_pc + 16'd1;
        end
        m_flush = 1'b0;
      end
      if (!was_busy && en && pre_size < DEPTH) begin
        m_busy   = 1'b1;
        m_req_pc = pre_next;
      end
    end
  endtask

  task automatic compare_model(input int cyc);
    check($sformatf("rnd%0d rd", cyc), instrmem_rd, m_busy);
    check($sformatf("rnd%0d PC", cyc), PC, m_req_pc);
    check($sformatf("rnd%0d valid", cyc), instr_valid, m_q.size() != 0);
    check($sformatf("rnd%0d count", cyc), pfq_count, m_q.size());
    check($sformatf("rnd%0d fetch_err", cyc), fetch_err, 0);
    if (m_q.size() != 0) begin
      check($sformatf("rnd%0d instr", cyc), instr, m_q[0].instr);
      check($sformatf("rnd%0d instr_pc", cyc), instr_pc, m_q[0].pc);
    end
  endtask

  initial begin
    int resp_wait;

    reset = 1'b0; fetch_en = 1'b0; instr_dout = '0; complete_instr = 1'b0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

    //             en cpl dout      rdy rdr rpc       rd PC        v ins       ipc       cnt
    vecs[0]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h3000, 0, 16'h0000, 16'h0000, 0);
    vecs[1]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h3000, 0, 16'h0000, 16'h0000, 0);
    vecs[2]  = mk(1, 1, 16'h1234, 0, 0, 16'h0000, 0, 16'h3000, 1, 16'h1234, 16'h3000, 1);
    vecs[3]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h3001, 1, 16'h1234, 16'h3000, 1);
    vecs[4]  = mk(1, 1, 16'h5678, 0, 0, 16'h0000, 0, 16'h3001, 1, 16'h1234, 16'h3000, 2);
    vecs[5]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h3001, 1, 16'h1234, 16'h3000, 2);
    vecs[6]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h3001, 1, 16'h1234, 16'h3000, 2);
    vecs[7]  = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h3001, 1, 16'h5678, 16'h3001, 1);
    vecs[8]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h3002, 1, 16'h5678, 16'h3001, 1);
    vecs[9]  = mk(1, 0, 16'h0000, 0, 1, 16'h4000, 1, 16'h3002, 0, 16'h0000, 16'h0000, 0);
    vecs[10] = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h3002, 0, 16'h0000, 16'h0000, 0);
    vecs[11] = mk(1, 1, 16'hDEAD, 0, 0, 16'h0000, 0, 16'h3002, 0, 16'h0000, 16'h0000, 0);
    vecs[12] = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h4000, 0, 16'h0000, 16'h0000, 0);
    vecs[13] = mk(1, 1, 16'h1111, 0, 0, 16'h0000, 0, 16'h4000, 1, 16'h1111, 16'h4000, 1);
    vecs[14] = mk(1, 0, 16'h0000, 0, 1, 16'hFFFF, 0, 16'h4000, 0, 16'h0000, 16'h0000, 0);
    vecs[15] = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 16'h0000, 16'h0000, 0);
    vecs[16] = mk(1, 1, 16'h0ABC, 0, 0, 16'h0000, 0, 16'hFFFF, 1, 16'h0ABC, 16'hFFFF, 1);
    vecs[17] = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    vecs[18] = mk(1, 1, 16'h2222, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h2222, 16'h0000, 1);
    vecs[19] = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0001, 1, 16'h2222, 16'h0000, 1);
    vecs[20] = mk(1, 1, 16'h3333, 1, 0, 16'h0000, 0, 16'h0001, 1, 16'h3333, 16'h0001, 1);
    vecs[21] = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'h3333, 16'h0001, 1);
    vecs[22] = mk(1, 1, 16'h4444, 1, 1, 16'h5000, 0, 16'h0002, 0, 16'h0000, 16'h0000, 0);
    vecs[23] = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h5000, 0, 16'h0000, 16'h0000, 0);
    vecs[24] = mk(0, 1, 16'h5555, 0, 0, 16'h0000, 0, 16'h5000, 1, 16'h5555, 16'h5000, 1);
    vecs[25] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h5000, 1, 16'h5555, 16'h5000, 1);
    vecs[26] = mk(0, 1, 16'h9999, 0, 0, 16'h0000, 0, 16'h5000, 1, 16'h5555, 16'h5000, 1);
    vecs[27] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h5000, 0, 16'h0000, 16'h0000, 0);

    repeat (2) @(negedge clock);
    check("reset rd", instrmem_rd, 0);
    check("reset PC", PC, 16'h0000);
    check("reset valid", instr_valid, 0);
    check("reset instr", instr, 16'h0000);
    check("reset instr_pc", instr_pc, 16'h0000);
    check("reset count", pfq_count, 0);
    check("reset fetch_err", fetch_err, 0);
    $display("reset: rd=%b PC=%h valid=%b count=%0d", instrmem_rd, PC, instr_valid, pfq_count);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      fetch_en = vecs[i].en; complete_instr = vecs[i].cpl; instr_dout = vecs[i].dout;
      instr_ready = vecs[i].rdy; redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      @(negedge clock);
      check($sformatf("row%0d rd", i), instrmem_rd, vecs[i].rd);
      check($sformatf("row%0d PC", i), PC, vecs[i].pc);
      check($sformatf("row%0d valid", i), instr_valid, vecs[i].v);
      check($sformatf("row%0d count", i), pfq_count, vecs[i].cnt);
      check($sformatf("row%0d fetch_err", i), fetch_err, 0);
      if (vecs[i].v) begin
        check($sformatf("row%0d instr", i), instr, vecs[i].ins);
        check($sformatf("row%0d instr_pc", i), instr_pc, vecs[i].ipc);
      end
      $display("row %0d: rd=%b PC=%h valid=%b instr=%h instr_pc=%h count=%0d",
               i, instrmem_rd, PC, instr_valid, instr, instr_pc, pfq_count);
    end

    // Reset asserted between edges while a request is outstanding and the queue holds data.
    fetch_en = 1'b1; complete_instr = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    @(negedge clock);
    check("pre-reset issue rd", instrmem_rd, 1);
    check("pre-reset issue PC", PC, 16'h5001);
    complete_instr = 1'b1; instr_dout = 16'hAAAA;
    @(negedge clock);
    check("pre-reset push count", pfq_count, 1);
    check("pre-reset push instr", instr, 16'hAAAA);
    complete_instr = 1'b0;
    @(negedge clock);
    check("pre-reset 2nd issue rd", instrmem_rd, 1);
    check("pre-reset 2nd issue PC", PC, 16'h5002);
    #2 reset = 1'b0;
    #1;
    check("async reset rd", instrmem_rd, 0);
    check("async reset valid", instr_valid, 0);
    check("async reset count", pfq_count, 0);
    check("async reset PC", PC, 16'h0000);
    $display("mid-request reset: rd=%b valid=%b count=%0d", instrmem_rd, instr_valid, pfq_count);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post-reset rd", instrmem_rd, 1);
    check("post-reset PC", PC, 16'h3000);
    $display("post-reset request: PC=%h rd=%b", PC, instrmem_rd);

`ifdef LC3_FETCH_TIMEOUT_EN
    for (int k = 1; k <= 64; k++) begin
      @(negedge clock);
      if (k < 64) begin
        check($sformatf("timeout wait%0d rd", k), instrmem_rd, 1);
        check($sformatf("timeout wait%0d fetch_err", k), fetch_err, 0);
      end else begin
        check("timeout rd", instrmem_rd, 0);
        check("timeout fetch_err", fetch_err, 1);
        check("timeout count", pfq_count, 0);
      end
    end
    @(negedge clock);
    check("retry rd", instrmem_rd, 1);
    check("retry PC", PC, 16'h3000);
    check("retry fetch_err sticky", fetch_err, 1);
    $display("timeout: fetch_err=%b retry PC=%h", fetch_err, PC);
`else
    for (int k = 1; k <= 70; k++) begin
      @(negedge clock);
      check($sformatf("wait%0d rd", k), instrmem_rd, 1);
      check($sformatf("wait%0d fetch_err", k), fetch_err, 0);
    end
    $display("no watchdog: request still pending at PC=%h", PC);
`endif
    complete_instr = 1'b1; instr_dout = 16'h7777;
    @(negedge clock);
    complete_instr = 1'b0; fetch_en = 1'b0;
    check("late complete rd", instrmem_rd, 0);
    check("late complete valid", instr_valid, 1);
    check("late complete instr", instr, 16'h7777);
    check("late complete instr_pc", instr_pc, 16'h3000);
    $display("late completion: instr=%h instr_pc=%h", instr, instr_pc);

    // Randomized traffic against the reference model.
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    resp_wait = $urandom_range(0, 3);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      fetch_en    = ($urandom_range(0, 9) != 0);
      instr_ready = $urandom_range(0, 1) != 0;
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2))
                                                : 16'($urandom);
      instr_dout  = 16'($urandom);
      if (m_busy) begin
        if (resp_wait == 0) begin
          complete_instr = 1'b1;
          resp_wait = $urandom_range(0, 3);
        end else begin
          complete_instr = 1'b0;
          resp_wait--;
        end
      end else begin
        complete_instr = ($urandom_range(0, 7) == 0);
      end
      if (!redirect && instr_ready && m_q.size() != 0)
        $display("rnd %0d: decode takes instr=%h pc=%h", cyc, m_q[0].instr, m_q[0].pc);
      model_step(fetch_en, complete_instr, instr_dout, instr_ready, redirect, redirect_pc);
      @(negedge clock);
      compare_model(cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
